bin_to_onehot_reg: RTL and testbench
====================================

// Module: bin_to_onehot_reg
// PURPOSE
//  Registered binary-to-one-hot decoder with valid/ready flow control; inverse of the one-hot encoder.
//  Turns a binary index (port/queue select, grant id) into a one-hot select vector for mux/enable fabrics.
//  Flags out-of-range indices and counts them.
//  Full throughput: one word per cycle, with a skid buffer so in_ready is a pure register output.
// PARAMETERS
//  ONEHOT_WIDTH   16                        width of decoded vector; any value >= 2, need not be a power of 2
//  BIN_WIDTH      $clog2(ONEHOT_WIDTH)      width of binary index input
//  ERR_CNT_WIDTH  8                         width of saturating out-of-range counter
// PORTS
//  clk         in   1              single clock, all state on rising edge
//  rst_n       in   1              asynchronous, active-low reset
//  in_valid    in   1              in_bin is valid this cycle
//  in_ready    out  1              block can accept; registered
//  in_bin      in   BIN_WIDTH      binary index to decode
//  out_valid   out  1              out_onehot/out_err are valid
//  out_ready   in   1              downstream accepts this cycle
//  out_onehot  out  ONEHOT_WIDTH   decoded vector; exactly one bit set when out_err=0, all zero when out_err=1
//  out_err     out  1              in_bin was >= ONEHOT_WIDTH
//  err_count   out  ERR_CNT_WIDTH  saturating count of accepted out-of-range words
//  err_clear   in   1              synchronous clear of err_count
// BEHAVIOUR
//  Clock/reset: one clock (clk); rst_n asynchronous assert, active low.
//  Reset values: out_valid=0, out_onehot=0, out_err=0, err_count=0, skid empty, in_ready=1.
//  Transfers: input transfer = in_valid&in_ready; output transfer = out_valid&out_ready.
//  Decode: onehot[i] = (in_bin == i); in_bin >= ONEHOT_WIDTH -> onehot=0, err=1. Decode happens before registering.
//  Latency: word accepted in cycle N appears on out_* in cycle N+1.
//  Ordering: output order equals input order; no drop, no duplication.
//  Holding: while out_valid=1 and out_ready=0, out_onehot/out_err hold stable.
//  Buffer states (main = output reg, skid = overflow reg):
//   EMPTY: main invalid. Input transfer -> load main -> ONE.
//   ONE:   main valid, skid empty.
//          in xfer & out xfer  -> main reloads, stay ONE.
//          in xfer only        -> word to skid -> FULL.
//          out xfer only       -> EMPTY.
//   FULL:  main + skid valid; in_ready=0.
//          out xfer -> skid moves to main -> ONE.
//  in_ready: registered as !FULL_next; never combinationally depends on out_ready.
//  err_count: +1 on each input transfer with in_bin >= ONEHOT_WIDTH; saturates at all-ones (no wrap).
//   err_clear alone -> 0.
//   err_clear with simultaneous erroneous transfer -> 1.
//  Power-of-2 widths: when ONEHOT_WIDTH == 2**BIN_WIDTH no index is out of range; out_err is constant 0 and the counter stays 0.
//  Reset mid-operation: all buffered words discarded; state returns to EMPTY immediately (async), err_count=0.
// STRUCTURE
//  Shared package/header: decode function bin_to_onehot_f(bin) and range-check function, for reuse by arbiters.
//  One sub-module: skid_buffer_2 (WIDTH = ONEHOT_WIDTH+1), generic 2-entry valid/ready skid buffer
//   carrying {err, onehot}.
//  Top level holds: decode logic ahead of skid_buffer_2, plus the error counter.
// TESTING
//  1. ONEHOT_WIDTH=16, out_ready=1, in_bin=0..15 back-to-back
//     -> out_onehot=16'h0001..16'h8000 one cycle later, no bubbles, out_err=0.
//  2. ONEHOT_WIDTH=12, in_bin=12,15,3
//     -> outputs (0,err=1),(0,err=1),(12'h008,err=0); err_count=2.
//  3. Stream in_bin=5,6,7 with out_ready=0 from cycle 1
//     -> in_ready falls after 2 accepts; out holds 16'h0020.
//     Release out_ready -> 0x0020,0x0040 then 0x0080 accepted and output; order preserved.
//  4. ERR_CNT_WIDTH=2, send 5 out-of-range words -> err_count sticks at 3.
//     err_clear coinciding with a 6th error -> err_count=1.
//  5. Assert rst_n=0 asynchronously while FULL
//     -> out_valid=0, in_ready=1, err_count=0 before next clk edge; no stale word emerges after release.
//  6. Random valid/ready stress, 10k words
//     -> scoreboard match; out_onehot popcount==1 iff !out_err; in_ready never asserted in FULL.

Source files
------------

// File: rtl/bin_to_onehot_reg_pkg.sv
// Shared decode helpers for binary-index to one-hot conversion, reused by
// this decoder and by arbiter logic that needs the same range rules.
//   bin_in_range_f  : 1 when bin addresses a real bit of a width-bit vector
//   bin_to_onehot_f : one-hot vector (MAX_ONEHOT_WIDTH wide, caller slices),
//                     all zero when bin is out of range
// Callers must keep width below MAX_ONEHOT_WIDTH and their index within
// MAX_BIN_WIDTH bits.
package bin_to_onehot_reg_pkg;

   localparam int unsigned MAX_ONEHOT_WIDTH = 1024;
   localparam int unsigned MAX_BIN_WIDTH    = 10;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_e;

   function automatic logic bin_in_range_f(input logic [MAX_BIN_WIDTH-1:0] bin,
                                           input int unsigned              width);
      return 32'(bin) < width;
   endfunction

   function automatic logic [MAX_ONEHOT_WIDTH-1:0] bin_to_onehot_f(
      input logic [MAX_BIN_WIDTH-1:0] bin,
      input int unsigned              width);
      logic [MAX_ONEHOT_WIDTH-1:0] onehot;
      onehot = '0;
      if (bin_in_range_f(bin, width)) begin
         onehot = MAX_ONEHOT_WIDTH'(1) << bin;
      end
      return onehot;
   endfunction

endpackage

// File: rtl/bin_to_onehot_reg_skid.sv
// skid_buffer_2: generic two-entry valid/ready skid buffer. Full throughput,
// in_ready comes straight from a flop so it never depends on out_ready.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    upstream handshake (in_ready registered)
//   in_data  [WIDTH]     upstream word
//   out_valid/out_ready  downstream handshake
//   out_data [WIDTH]     downstream word (the main register)
//
// state      | meaning
// -----------+------------------------------------------------------
// SKID_EMPTY | main register invalid, skid invalid
// SKID_ONE   | main register valid, skid invalid
// SKID_FULL  | main and skid valid, in_ready low
module skid_buffer_2
   import bin_to_onehot_reg_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   skid_state_e      state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_xfer, out_xfer;

   assign out_valid = (state_q != SKID_EMPTY);
   assign out_data  = main_q;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         SKID_EMPTY: begin
            if (in_xfer) begin
               main_d  = in_data;
               state_d = SKID_ONE;
            end
         end
         SKID_ONE: begin
            if (in_xfer && out_xfer) begin
               main_d = in_data;
            end else if (in_xfer) begin
               skid_d  = in_data;
               state_d = SKID_FULL;
            end else if (out_xfer) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_FULL: begin
            if (out_xfer) begin
               main_d  = skid_q;
               state_d = SKID_ONE;
            end
         end
         default: state_d = SKID_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SKID_EMPTY;
         main_q   <= '0;
         skid_q   <= '0;
         in_ready <= 1'b1;
      end else begin
         state_q  <= state_d;
         main_q   <= main_d;
         skid_q   <= skid_d;
         in_ready <= (state_d != SKID_FULL);
      end
   end

endmodule

// File: rtl/bin_to_onehot_reg.sv
// Registered binary-to-one-hot decoder with valid/ready flow control.
// Decodes ahead of a two-entry skid buffer carrying {err, onehot}, and keeps
// a saturating count of accepted out-of-range indices.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       input handshake (in_ready registered)
//   in_bin [BIN_WIDTH]      index to decode
//   out_valid/out_ready     output handshake
//   out_onehot [ONEHOT_WIDTH] decoded vector, zero on error
//   out_err                 index was >= ONEHOT_WIDTH
//   err_count [ERR_CNT_WIDTH] saturating out-of-range count
//   err_clear               synchronous clear of err_count
module bin_to_onehot_reg
   import bin_to_onehot_reg_pkg::*;
#(
   parameter int unsigned ONEHOT_WIDTH  = 16,
   parameter int unsigned BIN_WIDTH     = $clog2(ONEHOT_WIDTH),
   parameter int unsigned ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [BIN_WIDTH-1:0]     in_bin,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ONEHOT_WIDTH-1:0]  out_onehot,
   output logic                     out_err,
   output logic [ERR_CNT_WIDTH-1:0] err_count,
   input  logic                     err_clear
);

   localparam int unsigned DATA_WIDTH = ONEHOT_WIDTH + 1;

   logic [MAX_BIN_WIDTH-1:0]    bin_ext;
   logic [MAX_ONEHOT_WIDTH-1:0] onehot_full;
   logic                        in_err;
   logic [DATA_WIDTH-1:0]       in_word, out_word;
   logic                        in_xfer;
   logic                        unused_onehot_hi;

   assign bin_ext     = MAX_BIN_WIDTH'(in_bin);
   assign onehot_full = bin_to_onehot_f(bin_ext, ONEHOT_WIDTH);
   assign in_err      = !bin_in_range_f(bin_ext, ONEHOT_WIDTH);
   assign in_word     = {in_err, onehot_full[ONEHOT_WIDTH-1:0]};
   // Helper returns a fixed wide vector; only the low bits matter here.
   assign unused_onehot_hi = ^onehot_full[MAX_ONEHOT_WIDTH-1:ONEHOT_WIDTH];

   skid_buffer_2 #(
      .WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_word),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_word)
   );

   assign out_onehot = out_word[ONEHOT_WIDTH-1:0];
   assign out_err    = out_word[ONEHOT_WIDTH];
   assign in_xfer    = in_valid & in_ready;

   // A clear that coincides with an erroneous transfer keeps that one error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (err_clear) begin
         err_count <= (in_xfer && in_err) ? ERR_CNT_WIDTH'(1) : '0;
      end else if (in_xfer && in_err && (err_count != '1)) begin
         err_count <= err_count + ERR_CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_bin_to_onehot_reg.sv
module tb_bin_to_onehot_reg;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  in_bin = '0;
   logic        out_ready = 1'b0;
   logic        err_clear = 1'b0;

   logic        in_ready_a, out_valid_a, out_err_a;
   logic [15:0] out_onehot_a;
   logic [7:0]  err_count_a;
   logic        in_ready_b, out_valid_b, out_err_b;
   logic [11:0] out_onehot_b;
   logic [1:0]  err_count_b;

   int checks = 0;
   int failures = 0;

   logic [16:0] qa[$];
   logic [16:0] qb[$];
   logic [16:0] log_a[$];
   logic [16:0] log_b[$];
   int cnt_a = 0;
   int cnt_b = 0;

   always #5 clk = ~clk;

   // Power-of-two width: no index can be out of range.
   bin_to_onehot_reg #(.ONEHOT_WIDTH(16), .ERR_CNT_WIDTH(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_bin(in_bin), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_onehot(out_onehot_a), .out_err(out_err_a), .err_count(err_count_a),
      .err_clear(err_clear));

   // Non-power-of-two width with a tiny counter to reach saturation quickly.
   bin_to_onehot_reg #(.ONEHOT_WIDTH(12), .ERR_CNT_WIDTH(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_bin(in_bin), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_onehot(out_onehot_b), .out_err(out_err_b), .err_count(err_count_b),
      .err_clear(err_clear));

   // {err, onehot} expected for index b decoded to width w.
   function automatic logic [16:0] model_word(int w, int b);
      logic [16:0] r;
      r = '0;
      if (b < w) r[b] = 1'b1;
      else r[16] = 1'b1;
      return r;
   endfunction

   function automatic int model_count(int cnt, int maxv, bit hit, bit clr);
      if (clr) return hit ? 1 : 0;
      if (hit) return (cnt + 1 > maxv) ? maxv : cnt + 1;
      return cnt;
   endfunction

   // Drive one cycle from a negedge, score it against the queue model, and
   // return at the next negedge.
   task automatic cycle(input bit v, input int b, input bit r, input bit clr);
      bit          model_ready, in_x, out_x;
      logic [16:0] obs_a, obs_b;
      in_valid  = v;
      in_bin    = 4'(b);
      out_ready = r;
      err_clear = clr;
      #1;
      model_ready = (qa.size() < 2);
      checks++;
      if (out_valid_a !== (qa.size() != 0) || out_valid_b !== (qb.size() != 0)) begin
         failures++;
         $display("FAIL out_valid: a=%b b=%b expected %b", out_valid_a, out_valid_b, qa.size() != 0);
      end
      checks++;
      if (in_ready_a !== model_ready || in_ready_b !== model_ready) begin
         failures++;
         $display("FAIL in_ready: a=%b b=%b expected %b", in_ready_a, in_ready_b, model_ready);
      end
      checks++;
      if (err_count_a !== 8'(cnt_a) || err_count_b !== 2'(cnt_b)) begin
         failures++;
         $display("FAIL err_count: a=%0d b=%0d expected a=%0d b=%0d", err_count_a, err_count_b, cnt_a, cnt_b);
      end
      obs_a = {out_err_a, out_onehot_a};
      obs_b = {out_err_b, 4'b0000, out_onehot_b};
      if (qa.size() != 0) begin
         checks++;
         if (obs_a !== qa[0] || obs_b !== qb[0]) begin
            failures++;
            $display("FAIL out_data: a=%h b=%h expected a=%h b=%h", obs_a, obs_b, qa[0], qb[0]);
         end
         checks++;
         if ((($countones(out_onehot_a) == 1) == out_err_a) ||
             (($countones(out_onehot_b) == 1) == out_err_b)) begin
            failures++;
            $display("FAIL onehot_popcount: a=%h/%b b=%h/%b", out_onehot_a, out_err_a, out_onehot_b, out_err_b);
         end
      end
      out_x = (qa.size() != 0) && r;
      in_x  = v && model_ready;
      if (out_x) begin
         log_a.push_back(obs_a);
         log_b.push_back(obs_b);
         void'(qa.pop_front());
         void'(qb.pop_front());
      end
      if (in_x) begin
         qa.push_back(model_word(16, b));
         qb.push_back(model_word(12, b));
      end
      cnt_a = model_count(cnt_a, 255, in_x && b >= 16, clr);
      cnt_b = model_count(cnt_b, 3, in_x && b >= 12, clr);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0 || in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
         failures++;
         $display("FAIL reset_handshake: ov=%b/%b ir=%b/%b expected 0/0 1/1", out_valid_a, out_valid_b, in_ready_a, in_ready_b);
      end
      checks++;
      if (out_onehot_a !== 16'h0 || out_onehot_b !== 12'h0 || out_err_a !== 1'b0 || out_err_b !== 1'b0) begin
         failures++;
         $display("FAIL reset_data: a=%h/%b b=%h/%b expected zeros", out_onehot_a, out_err_a, out_onehot_b, out_err_b);
      end
      checks++;
      if (err_count_a !== 8'd0 || err_count_b !== 2'd0) begin
         failures++;
         $display("FAIL reset_count: a=%0d b=%0d expected 0", err_count_a, err_count_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      log_a.delete(); log_b.delete();
      for (int i = 0; i < 16; i++) cycle(1, i, 1, 0);
      cycle(0, 0, 1, 0);
      checks++;
      if (log_a.size() != 16) begin
         failures++;
         $display("FAIL b2b_count: got %0d words expected 16", log_a.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (log_a[i] !== (17'd1 << i)) begin
               failures++;
               $display("FAIL b2b_word%0d: got %h expected %h", i, log_a[i], 17'd1 << i);
            end
         end
      end
   endtask

   task automatic test_out_of_range();
      logic [16:0] exp_w[3];
      exp_w = '{17'h10000, 17'h10000, 17'h00008};
      cycle(0, 0, 1, 1);
      log_a.delete(); log_b.delete();
      cycle(1, 12, 1, 0);
      cycle(1, 15, 1, 0);
      cycle(1, 3, 1, 0);
      cycle(0, 0, 1, 0);
      checks++;
      if (log_b.size() != 3) begin
         failures++;
         $display("FAIL oor_count: got %0d words expected 3", log_b.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_b[i] !== exp_w[i]) begin
               failures++;
               $display("FAIL oor_word%0d: got %h expected %h", i, log_b[i], exp_w[i]);
            end
         end
      end
      checks++;
      if (err_count_b !== 2'd2) begin
         failures++;
         $display("FAIL oor_err_count: got %0d expected 2", err_count_b);
      end
   endtask

   task automatic test_backpressure();
      logic [16:0] exp_w[3];
      exp_w = '{17'h00020, 17'h00040, 17'h00080};
      log_a.delete(); log_b.delete();
      cycle(1, 5, 0, 0);
      cycle(1, 6, 0, 0);
      checks++;
      if (in_ready_a !== 1'b0 || out_onehot_a !== 16'h0020) begin
         failures++;
         $display("FAIL bp_full: in_ready=%b out=%h expected 0 0020", in_ready_a, out_onehot_a);
      end
      cycle(1, 7, 0, 0);
      checks++;
      if (out_onehot_a !== 16'h0020 || out_valid_a !== 1'b1) begin
         failures++;
         $display("FAIL bp_hold: out=%h valid=%b expected 0020 1", out_onehot_a, out_valid_a);
      end
      cycle(1, 7, 1, 0);
      cycle(1, 7, 1, 0);
      cycle(0, 0, 1, 0);
      checks++;
      if (log_a.size() != 3) begin
         failures++;
         $display("FAIL bp_count: got %0d words expected 3", log_a.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_a[i] !== exp_w[i]) begin
               failures++;
               $display("FAIL bp_order%0d: got %h expected %h", i, log_a[i], exp_w[i]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      cycle(0, 0, 1, 1);
      for (int k = 0; k < 5; k++) cycle(1, 12 + (k % 4), 1, 0);
      cycle(0, 0, 1, 0);
      checks++;
      if (err_count_b !== 2'd3 || err_count_a !== 8'd0) begin
         failures++;
         $display("FAIL sat_stick: b=%0d a=%0d expected 3 0", err_count_b, err_count_a);
      end
      cycle(1, 14, 1, 1);
      cycle(0, 0, 1, 0);
      checks++;
      if (err_count_b !== 2'd1) begin
         failures++;
         $display("FAIL sat_clear_with_err: got %0d expected 1", err_count_b);
      end
   endtask

   task automatic test_async_reset();
      cycle(1, 13, 0, 0);
      cycle(1, 5, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0 || in_ready_a !== 1'b1 ||
          in_ready_b !== 1'b1 || err_count_b !== 2'd0 || out_onehot_a !== 16'h0) begin
         failures++;
         $display("FAIL async_reset: ov=%b/%b ir=%b/%b cnt_b=%0d out_a=%h expected 0/0 1/1 0 0",
                  out_valid_a, out_valid_b, in_ready_a, in_ready_b, err_count_b, out_onehot_a);
      end
      qa.delete(); qb.delete();
      cnt_a = 0; cnt_b = 0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
   endtask

   task automatic test_random();
      int accepted = 0;
      int budget = 60000;
      bit v, r, clr;
      int b;
      while (accepted < 10000 && budget > 0) begin
         v   = ($urandom_range(0, 3) != 0);
         r   = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 63) == 0);
         b   = $urandom_range(0, 15);
         if (v && qa.size() < 2) accepted++;
         cycle(v, b, r, clr);
         budget--;
      end
      checks++;
      if (accepted < 10000) begin
         failures++;
         $display("FAIL random_budget: accepted %0d expected 10000", accepted);
      end
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
      checks++;
      if (qa.size() != 0) begin
         failures++;
         $display("FAIL random_drain: %0d words left expected 0", qa.size());
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_out_of_range();
      test_backpressure();
      test_saturation();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
